// File: rtl/fixed_point_addsub_pipe_pkg.sv
// Shared types and saturation limits for the fixed-point add/sub datapath.
`ifndef FIXED_W
`define FIXED_W 16
`endif

package fixed_point;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ACC  = 2'd2,
    LOAD = 2'd3
  } addsub_op_t;

  // Largest positive two's-complement value that fits in w bits (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < w - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value that fits in w bits (w <= 64).
  function automatic logic [63:0] sat_min(input int w);
    logic [63:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fixed_point_sat_add.sv
// Combinational WIDTH+1-bit signed add/subtract with wrap or saturate and an overflow flag.
module fixed_point_sat_add
  import fixed_point::*;
#(
  parameter int WIDTH = `FIXED_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  localparam logic [63:0] MAX64 = sat_max(WIDTH);
  localparam logic [63:0] MIN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] MAX_W = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_W = MIN64[WIDTH-1:0];

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] sum_ext;

  // One extra bit keeps a - min exact; the true sign is then sum_ext[WIDTH].
  always_comb begin
    a_ext      = {a_i[WIDTH-1], a_i};
    b_ext      = {b_i[WIDTH-1], b_i};
    sum_ext    = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    overflow_o = sum_ext[WIDTH] != sum_ext[WIDTH-1];
    result_o   = sum_ext[WIDTH-1:0];
    if (overflow_o && sat_i) begin
      result_o = sum_ext[WIDTH] ? MIN_W : MAX_W;
    end
  end

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage valid/ready fixed-point add/sub/accumulate pipe with sticky overflow status.
module fixed_point_addsub_pipe
  import fixed_point::*;
#(
  parameter int WIDTH = `FIXED_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  addsub_op_t       in_op,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic [WIDTH-1:0] acc_value,
  output logic             ovf_sticky,
  input  logic             sticky_clr
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // A producer holds its payload stable while valid is 1 and ready is 0.

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_op1_q, s1_op2_q;
  addsub_op_t       s1_op_q;
  logic             s1_sat_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_ovf_q, s2_ovf_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             s2_adv, s1_adv, accept;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic             alu_ovf;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  // ACC reads acc as the first addend; op1 becomes the second.
  always_comb begin
    alu_a = s1_op1_q;
    alu_b = s1_op2_q;
    if (s1_op_q == ACC) begin
      alu_a = acc_q;
      alu_b = s1_op1_q;
    end
  end

  fixed_point_sat_add #(.WIDTH(WIDTH)) u_sat_add (
    .a_i        (alu_a),
    .b_i        (alu_b),
    .sub_i      (s1_op_q == SUB),
    .sat_i      (s1_sat_q),
    .result_o   (alu_res),
    .overflow_o (alu_ovf)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_ovf_d    = s2_ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (accept) s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      if (s1_op_q == LOAD) begin
        s2_result_d = s1_op1_q;
        s2_ovf_d    = 1'b0;
      end else begin
        s2_result_d = alu_res;
        s2_ovf_d    = alu_ovf;
      end
      if (s1_op_q == ACC || s1_op_q == LOAD) acc_d = s2_result_d;
      if (s2_ovf_d) sticky_d = 1'b1;
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end

    if (sticky_clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op1_q    <= '0;
      s1_op2_q    <= '0;
      s1_op_q     <= ADD;
      s1_sat_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_ovf_q    <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_ovf_q    <= s2_ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      if (accept) begin
        s1_op1_q <= in_op1;
        s1_op2_q <= in_op2;
        s1_op_q  <= in_op;
        s1_sat_q <= in_sat;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_overflow = s2_ovf_q;
  assign acc_value    = acc_q;
  assign ovf_sticky   = sticky_q;

endmodule
